// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory arbiter family: FSM encoding, access
// direction constants and a one-hot to index helper.
package mem_arb_pkg;

   localparam int MAX_CH = 8;
   localparam int IDX_W  = 3;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic RD = 1'b0;
   localparam logic WR = 1'b1;

   function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_CH-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner selection: fixed priority (lowest index) or
// round-robin scanning upward from rr_ptr with wrap.
module arb_select
   import mem_arb_pkg::*;
#(
   parameter int N_CH = 3
) (
   input  logic [N_CH-1:0]  req,
   input  logic [IDX_W-1:0] rr_ptr,
   input  logic             mode,
   output logic [N_CH-1:0]  winner,
   output logic [IDX_W-1:0] win_idx
);

   logic [N_CH-1:0]   upper;
   logic [N_CH-1:0]   scan;
   logic [MAX_CH-1:0] win_ext;

   // Round-robin = lowest request at or above rr_ptr, else lowest overall.
   always_comb begin
      upper = '0;
      for (int i = 0; i < N_CH; i++) begin
         upper[i] = (IDX_W'(i) >= rr_ptr);
      end
      scan    = (mode && |(req & upper)) ? (req & upper) : req;
      winner  = scan & (~scan + N_CH'(1));
      win_ext = '0;
      win_ext[N_CH-1:0] = winner;
      win_idx = onehot_to_index(win_ext);
   end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel memory arbiter: serialises per-channel read/write requests onto
// one memory port and returns a one-cycle ack (plus read data) to the winner.
module mem_arbiter_n
   import mem_arb_pkg::*;
#(
   parameter int N_CH    = 3,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 14,
   parameter int RD_LAT  = 1,
   parameter int RR_MODE = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_CH-1:0]          req,
   input  logic [N_CH-1:0]          req_wr,
   input  logic [N_CH*ADDR_W-1:0]   req_addr,
   input  logic [N_CH*DATA_W-1:0]   req_wdata,
   output logic [N_CH-1:0]          grant,
   output logic [N_CH-1:0]          ack,
   output logic [DATA_W-1:0]        rdata,
   output logic                     busy,
   output logic                     mem_re,
   output logic                     mem_we,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata
);

   localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);
   localparam logic       MODE     = 1'(RR_MODE != 0);

   state_t            state;
   logic              dir;
   logic [1:0]        lat_cnt;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  rr_next;
   logic [IDX_W-1:0]  win_idx;
   logic [N_CH-1:0]   win_oh;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_wr;

   arb_select #(.N_CH(N_CH)) u_sel (
      .req     (req),
      .rr_ptr  (rr_ptr),
      .mode    (MODE),
      .winner  (win_oh),
      .win_idx (win_idx)
   );

   // Payload mux driven by the one-hot winner, so no index range issues.
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (win_oh[i]) begin
            sel_addr  = sel_addr  | req_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = sel_wdata | req_wdata[i*DATA_W +: DATA_W];
         end
      end
      sel_wr  = |(req_wr & win_oh);
      rr_next = (win_idx == IDX_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ARB;
         grant     <= '0;
         ack       <= '0;
         rdata     <= '0;
         busy      <= 1'b0;
         mem_re    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         dir       <= RD;
         rr_ptr    <= '0;
         lat_cnt   <= '0;
      end else begin
         mem_re <= 1'b0;
         mem_we <= 1'b0;
         ack    <= '0;
         case (state)
            ARB: begin
               if (|req) begin
                  grant     <= win_oh;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  dir       <= sel_wr;
                  mem_we    <= (sel_wr == WR);
                  mem_re    <= (sel_wr == RD);
                  rr_ptr    <= rr_next;
                  busy      <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               if (dir == WR) begin
                  ack   <= grant;
                  state <= DONE;
               end else if (RD_LAT == 1) begin
                  lat_cnt <= LAT_LOAD;
                  rdata   <= mem_rdata;
                  ack     <= grant;
                  state   <= DONE;
               end else begin
                  lat_cnt <= LAT_LOAD;
                  state   <= WAIT;
               end
            end
            // Leaving WAIT on the last count so read data lands on DONE entry.
            WAIT: begin
               lat_cnt <= lat_cnt - 1'b1;
               if (lat_cnt == 2'd1) begin
                  rdata <= mem_rdata;
                  ack   <= grant;
                  state <= DONE;
               end
            end
            DONE: begin
               grant <= '0;
               busy  <= 1'b0;
               state <= ARB;
            end
            default: state <= ARB;
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter_n.md
Name: mem_arbiter_n

Overview:
Parametrised N-channel memory arbiter. It is the next generation of the fixed three-requester (ROM read / RAM read / RAM write) memory resolver. Pipeline stages (fetch, decode, write-back, later DMA/stack) raise per-channel requests carrying address, direction and write data. The arbiter serialises them onto a single memory port and returns a one-cycle acknowledge, plus read data, to the winner. Channel count, widths, read latency and arbitration mode (fixed priority or round-robin) are selectable.

Parameters:
N_CH, 3, number of requesting channels (2..8); channel 0 = highest fixed priority
ADDR_W, 12, address width
DATA_W, 14, data width
RD_LAT, 1, memory read latency in cycles (1..4), mem_rdata valid RD_LAT cycles after mem_re
RR_MODE, 0, 0 = fixed priority, 1 = round-robin

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req  in  N_CH  per-channel request; held high with payload stable until ack
req_wr  in  N_CH  per-channel direction, 1 = write, 0 = read
req_addr  in  N_CH*ADDR_W  per-channel address, channel i at bits [i*ADDR_W +: ADDR_W]
req_wdata  in  N_CH*DATA_W  per-channel write data, same packing
grant  out  N_CH  one-hot, registered; high from winner selection until ack inclusive
ack  out  N_CH  one-hot single-cycle completion pulse
rdata  out  DATA_W  read data, valid in the ack cycle of a read
busy  out  1  high whenever state != ARB
mem_re  out  1  memory read strobe, one cycle
mem_we  out  1  memory write strobe, one cycle
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (reset low, async): state=ARB, grant=0, ack=0, rdata=0, busy=0, mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0, rr_ptr=0, latency counter=0.
- FSM states: ARB, ISSUE, WAIT, DONE.
- ARB: if any req, select winner, register grant, latch winner's addr/wr/wdata into mem_addr/mem_wdata and internal dir, go to ISSUE. If no req, stay in ARB.
- ISSUE, one cycle: mem_we=1 for a write, mem_re=1 for a read. Write goes to DONE. Read loads counter=RD_LAT-1; it goes to DONE if RD_LAT=1, otherwise to WAIT.
- WAIT: decrement the counter; at 0 go to DONE.
- DONE, one cycle: ack[winner]=1, grant held. For a read, rdata captures mem_rdata on entry so it is valid during DONE. rdata holds its last value otherwise. Then go to ARB; grant clears.
- Latency from req to ack: write 3 cycles; read 3+RD_LAT-1 cycles. Back-to-back accesses cost one ARB cycle each.
- Fixed priority: the lowest-indexed asserted req wins.
- Round-robin: scan starts at rr_ptr, wrapping modulo N_CH. After each grant, rr_ptr = winner+1, with wrap N_CH-1 -> 0.
- Payload is sampled only in ARB. Changing req_addr/req_wdata after grant has no effect.
- Dropping req before ack is a protocol violation. The access still completes and ack still pulses.
- New requests arriving during ISSUE/WAIT/DONE are only considered in the next ARB.
- Simultaneous ack and a new req from the same channel: that req is evaluated in the following ARB like any other.
- reset asserted mid-access aborts immediately. Strobes drop and no ack is issued.
- grant and ack are always one-hot or zero. Exactly one mem strobe is issued per access.

Decomposition:
- Shared package mem_arb_pkg: state encoding localparams (ARB, ISSUE, WAIT, DONE), direction constants RD/WR, and a function onehot_to_index.
- One sub-module: arb_select. It is purely combinational: inputs req, rr_ptr and mode; outputs a one-hot winner and its index. It is instantiated once and is reusable for future stack/GPR arbiters.
- The FSM, payload mux, latency counter and pointer stay in mem_arbiter_n.

Test Plan:
- Reset mid-read (RD_LAT=2): reset low in WAIT -> grant=0, mem_re=0, no ack; after release, state=ARB and rr_ptr=0.
- Single write: ch1 req, wr=1, addr=0x0A5, wdata=0x1234 -> mem_we one cycle with addr 0x0A5 / data 0x1234; ack=3'b010 on the third cycle after req.
- Single read, RD_LAT=3: ch0 reads 0x100, memory returns 0x2AAA three cycles after mem_re -> ack=3'b001 with rdata=0x2AAA; total 5 cycles from req.
- Fixed priority: ch0, ch1, ch2 all requesting continuously -> ch0 granted every time; ch2 is never acked while ch0 is held.
- Round-robin (RR_MODE=1): all three requesting continuously -> ack order 0,1,2,0,1,2. Start with rr_ptr=2 and only ch0/ch2 requesting -> ch2 first, then ch0.
- N_CH=8, ADDR_W=16 build: ch7 writes 0xFFFF -> correct slice used, mem_addr=0xFFFF, ack[7] only. Payload changed after grant -> memory still sees the latched values.
